axi_bypass_adapter: RTL
=======================

AXI_BYPASS_ADAPTER -- requirements
Module: axi_bypass_adapter

Interface
REQ-001 Parameter AddrW, 64, request/AXI address width.
REQ-002 Parameter DataW, 64, data width; strobe width DataW/8.
REQ-003 Parameter AxiId, 0, constant ID driven on aw_id_o/ar_id_o.
REQ-004 Port clk_i in 1 clock; rst_ni in 1 reset, asynchronous, active-low.
REQ-005 req_valid_i in 1, req_ready_o out 1: single-request handshake from upstream cache FSM.
REQ-006 req_we_i in 1 (1=write), req_addr_i in AddrW, req_size_i in 2 (log2 bytes), req_wdata_i in DataW, req_be_i in DataW/8.
REQ-007 kill_i in 1: abort pending read before address issue.
REQ-008 rsp_valid_o out 1 (one-cycle pulse), rsp_rdata_o out DataW, rsp_err_o out 1.
REQ-009 aw_valid_o out 1, aw_ready_i in 1, aw_addr_o out AddrW, aw_size_o out 3, aw_id_o out 4.
REQ-010 w_valid_o out 1, w_ready_i in 1, w_data_o out DataW, w_strb_o out DataW/8, w_last_o out 1.
REQ-011 b_valid_i in 1, b_ready_o out 1, b_resp_i in 2.
REQ-012 ar_valid_o out 1, ar_ready_i in 1, ar_addr_o out AddrW, ar_size_o out 3, ar_id_o out 4.
REQ-013 r_valid_i in 1, r_ready_o out 1, r_data_i in DataW, r_resp_i in 2, r_last_i in 1.

Function
REQ-014 FSM states SHALL be IDLE, RD_AR, RD_R, WR_REQ, WR_B.
REQ-015 req_ready_o SHALL be 1 only in IDLE; accept = req_valid_i & req_ready_o.
REQ-016 On accept, addr/size/we/wdata/be SHALL be registered; next state RD_AR (we=0) or WR_REQ (we=1).
REQ-017 RD_AR: ar_valid_o=1, ar_addr_o/ar_size_o={1'b0,size} from registers, held stable until ar_ready_i; then RD_R.
REQ-018 RD_AR with kill_i=1 and no same-cycle ar_ready_i: return to IDLE, no AR issued, no response; kill_i ignored in all other states.
REQ-019 RD_R: r_ready_o=1; first beat data SHALL be captured; on r_valid_i&r_last_i, rsp_valid_o=1 next cycle with captured (or same-beat) data, state IDLE.
REQ-020 Non-last R beats SHALL be consumed without response; response returns first-beat data.
REQ-021 WR_REQ: aw_valid_o and w_valid_o SHALL assert together in the first WR_REQ cycle; each deasserts independently after its own handshake (sticky aw_done/w_done).
REQ-022 W and AW handshakes in any order or same cycle SHALL be legal; transition to WR_B when both done.
REQ-023 w_last_o SHALL be constant 1; w_data_o/w_strb_o from registered wdata/be.
REQ-024 WR_B: b_ready_o=1; on b_valid_i, rsp_valid_o pulse next cycle, rsp_rdata_o=0, state IDLE.
REQ-025 Minimum latency: accept to ar_valid_o/aw_valid_o = 1 cycle; last R/B handshake to rsp_valid_o = 1 cycle.
REQ-026 Only one transaction outstanding; b_ready_o/r_ready_o SHALL be 0 outside WR_B/RD_R.
REQ-027 rsp_valid_o SHALL assert in the IDLE cycle following completion, during which a new request may be accepted.

Reset
REQ-028 On rst_ni=0: state IDLE, all valid/ready outputs 0 except req_ready_o=1 after reset release, rsp_rdata_o=0, rsp_err_o=0, done flags 0.
REQ-029 Reset mid-transaction SHALL abandon it silently; no response after release.

Configuration
REQ-030 Macro AXI_BYPASS_ADAPTER_ERR_EN defined: rsp_err_o=1 with rsp_valid_o if r_resp_i[1] (any beat) or b_resp_i[1] was set.
REQ-031 Macro undefined: rsp_err_o tied 0; r_resp_i/b_resp_i ignored.

Verification
REQ-032 Read addr 0x8000_0010 size 3, ar_ready_i delayed 3 cycles, R data 0xDEAD_BEEF_0123_4567 last=1 -> one AR with size 3, rsp_valid_o 1 cycle later with that data.
REQ-033 Write addr 0x8000_0020 be 0x0F, w_ready_i 2 cycles before aw_ready_i -> single W and single AW handshake, b_valid_i -> single rsp_valid_o, rsp_rdata_o=0.
REQ-034 Read accept then kill_i=1 in RD_AR with ar_ready_i=0 -> no AR handshake, no rsp_valid_o, req_ready_o=1 next cycle.
REQ-035 R burst of 2 beats (0x11, 0x22, last on 2nd) -> one rsp_valid_o with data 0x11.
REQ-036 ERR_EN defined, b_resp_i=2'b10 -> rsp_err_o=1; undefined -> rsp_err_o=0.
REQ-037 rst_ni asserted in WR_B, then released, b_valid_i pulse -> no rsp_valid_o, state IDLE.

Source files
------------

// File: rtl/axi_bypass_adapter.sv
// Single-beat uncached bridge from a cache-FSM request port onto AXI AW/W/B and AR/R; one transaction in flight.
// Latency: accept -> AR/AW valid 1 cycle, last R / B handshake -> rsp_valid_o 1 cycle.
// Backpressure: req_ready_o only in IDLE; AXI channels held stable until ready. AXI_BYPASS_ADAPTER_ERR_EN enables rsp_err_o.
module axi_bypass_adapter #(
    parameter int unsigned AddrW = 64,
    parameter int unsigned DataW = 64,
    parameter logic [3:0]  AxiId = 4'd0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrW-1:0]     req_addr_i,
    input  logic [1:0]           req_size_i,
    input  logic [DataW-1:0]     req_wdata_i,
    input  logic [DataW/8-1:0]   req_be_i,
    input  logic                 kill_i,
    output logic                 rsp_valid_o,
    output logic [DataW-1:0]     rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 aw_valid_o,
    input  logic                 aw_ready_i,
    output logic [AddrW-1:0]     aw_addr_o,
    output logic [2:0]           aw_size_o,
    output logic [3:0]           aw_id_o,
    output logic                 w_valid_o,
    input  logic                 w_ready_i,
    output logic [DataW-1:0]     w_data_o,
    output logic [DataW/8-1:0]   w_strb_o,
    output logic                 w_last_o,
    input  logic                 b_valid_i,
    output logic                 b_ready_o,
    input  logic [1:0]           b_resp_i,
    output logic                 ar_valid_o,
    input  logic                 ar_ready_i,
    output logic [AddrW-1:0]     ar_addr_o,
    output logic [2:0]           ar_size_o,
    output logic [3:0]           ar_id_o,
    input  logic                 r_valid_i,
    output logic                 r_ready_o,
    input  logic [DataW-1:0]     r_data_i,
    input  logic [1:0]           r_resp_i,
    input  logic                 r_last_i
);

    localparam int unsigned StrbW = DataW / 8;

    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_REQ, WR_B} state_e;

    typedef struct packed {
        logic [AddrW-1:0] addr;
        logic [1:0]       size;
        logic [DataW-1:0] wdata;
        logic [StrbW-1:0] be;
    } req_t;

    state_e           state_q, state_d;
    req_t             req_q;
    logic             aw_done_q, w_done_q;
    logic             beat_seen_q;
    logic [DataW-1:0] rdata_q;
    logic             rsp_valid_q;
    logic [DataW-1:0] rsp_rdata_q;

    logic accept, aw_hs, w_hs, r_hs, b_hs, aw_fin, w_fin;

    assign accept = req_valid_i & req_ready_o;
    assign aw_hs  = aw_valid_o & aw_ready_i;
    assign w_hs   = w_valid_o & w_ready_i;
    assign r_hs   = r_valid_i & r_ready_o;
    assign b_hs   = b_valid_i & b_ready_o;
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q | w_hs;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = req_we_i ? WR_REQ : RD_AR;
            // A kill loses to a same-cycle AR handshake: the read is already out.
            RD_AR:   if (ar_ready_i) state_d = RD_R;
                     else if (kill_i) state_d = IDLE;
            RD_R:    if (r_hs && r_last_i) state_d = IDLE;
            WR_REQ:  if (aw_fin && w_fin) state_d = WR_B;
            WR_B:    if (b_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = 1'b0;
        ar_valid_o  = 1'b0;
        r_ready_o   = 1'b0;
        aw_valid_o  = 1'b0;
        w_valid_o   = 1'b0;
        b_ready_o   = 1'b0;
        unique case (state_q)
            IDLE:    req_ready_o = 1'b1;
            RD_AR:   ar_valid_o  = 1'b1;
            RD_R:    r_ready_o   = 1'b1;
            WR_REQ: begin
                aw_valid_o = ~aw_done_q;
                w_valid_o  = ~w_done_q;
            end
            WR_B:    b_ready_o   = 1'b1;
            default: req_ready_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q       <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            beat_seen_q <= 1'b0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (accept) begin
                req_q.addr  <= req_addr_i;
                req_q.size  <= req_size_i;
                req_q.wdata <= req_wdata_i;
                req_q.be    <= req_be_i;
                aw_done_q   <= 1'b0;
                w_done_q    <= 1'b0;
                beat_seen_q <= 1'b0;
            end
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
            if (r_hs && !beat_seen_q) begin
                rdata_q     <= r_data_i;
                beat_seen_q <= 1'b1;
            end
            // Single-beat bursts return the live beat; longer ones the captured first beat.
            if (r_hs && r_last_i) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= beat_seen_q ? rdata_q : r_data_i;
            end
            if (b_hs) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= '0;
            end
        end
    end

`ifdef AXI_BYPASS_ADAPTER_ERR_EN
    logic err_q, rsp_err_q;
    logic unused_resp_lsb;
    assign unused_resp_lsb = r_resp_i[0] ^ b_resp_i[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q     <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            if (accept)          err_q <= 1'b0;
            else if (r_hs)       err_q <= err_q | r_resp_i[1];
            if (r_hs && r_last_i) rsp_err_q <= err_q | r_resp_i[1];
            else if (b_hs)        rsp_err_q <= b_resp_i[1];
        end
    end
    assign rsp_err_o = rsp_err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{r_resp_i, b_resp_i};
    assign rsp_err_o   = 1'b0;
`endif

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign aw_addr_o   = req_q.addr;
    assign aw_size_o   = {1'b0, req_q.size};
    assign aw_id_o     = AxiId;
    assign w_data_o    = req_q.wdata;
    assign w_strb_o    = req_q.be;
    assign w_last_o    = 1'b1;
    assign ar_addr_o   = req_q.addr;
    assign ar_size_o   = {1'b0, req_q.size};
    assign ar_id_o     = AxiId;

endmodule
